feature_writeback_ctrl: RTL and testbench

Next-generation write-back stage for GAT layer outputs. Accepts full new-feature vectors from the aggregator over a valid/ready handshake and buffers them in an internal FIFO. Serialises each vector into LANES-wide words for the new-feature BRAM, applying a runtime-selectable arithmetic right shift. Signals layer completion after a runtime-programmed node count; supports a different feature count per layer without re-synthesis.

---
 rtl/feature_writeback_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_feature_writeback_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_writeback_ctrl.sv
// GAT write-back: buffers feature vectors in a FIFO and serialises them into LANES-wide BRAM words, with a per-layer arithmetic shift.
// First BRAM write lands 2 cycles after acceptance; ready drops when the FIFO is full or the layer quota is met. Define FEAT_RELU_EN to clamp negatives to 0 before the shift.
`timescale 1ns/1ps

module feature_writeback_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  assign pop_dat = mem[rd_ptr];
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_dat;
  end
endmodule

module feature_writeback_ctrl #(
  parameter int FEAT_W          = 32,
  parameter int NUM_FEAT_MAX    = 16,
  parameter int LANES           = 2,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_NODES_TOTAL = 2708,
  parameter int ADDR_W          = $clog2(MAX_NODES_TOTAL*NUM_FEAT_MAX/LANES),
  parameter int NF_W            = $clog2(NUM_FEAT_MAX+1),
  parameter int NN_W            = $clog2(MAX_NODES_TOTAL+1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NF_W-1:0]                num_feat,
  input  logic [NN_W-1:0]                num_nodes,
  input  logic [4:0]                     shift_amt,
  input  logic [NUM_FEAT_MAX*FEAT_W-1:0] new_feat,
  input  logic                           new_feat_vld,
  output logic                           new_feat_rdy,
  output logic [ADDR_W-1:0]              feat_bram_addra,
  output logic [LANES*FEAT_W-1:0]        feat_bram_din,
  output logic                           feat_bram_ena,
  output logic                           busy,
  output logic                           gat_ready
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int BW = NF_W + 1;
  localparam int LW = $clog2(LANES);
  localparam int VW = NUM_FEAT_MAX*FEAT_W;

  logic [1:0]           state;
  logic [NF_W-1:0]      num_feat_q;
  logic [NN_W-1:0]      num_nodes_q;
  logic [4:0]           shift_q;
  logic [BW-1:0]        beats_q;
  logic [BW-1:0]        beats_next;
  logic [BW-1:0]        beat_idx;
  logic [NN_W-1:0]      accept_cnt;
  logic [NN_W-1:0]      node_cnt;
  logic [ADDR_W-1:0]    addr_cnt;
  logic                 active;
  logic [VW-1:0]        cur_vec;
  logic [VW-1:0]        fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 run;
  logic                 push;
  logic                 pop;
  logic                 last_beat;
  logic                 layer_end;
  logic [LANES*FEAT_W-1:0] lane_dat;

  function automatic logic [FEAT_W-1:0] xform(input logic [FEAT_W-1:0] e, input logic [4:0] sh);
    logic signed [FEAT_W-1:0] s;
    s = $signed(e);
`ifdef FEAT_RELU_EN
    if (s[FEAT_W-1]) s = '0;
`endif
    return s >>> sh;
  endfunction

  function automatic logic [FEAT_W-1:0] lane_elem(input logic [VW-1:0] vec, input int idx);
    lane_elem = '0;
    for (int k = 0; k < NUM_FEAT_MAX; k++) begin
      if (k == idx) lane_elem = vec[k*FEAT_W +: FEAT_W];
    end
  endfunction

  assign run          = (state == RUN);
  assign busy         = run;
  assign new_feat_rdy = run && !fifo_full && (accept_cnt < num_nodes_q);
  assign push         = new_feat_vld && new_feat_rdy;
  assign beats_next   = BW'((32'(num_feat) + LANES - 1) >> LW);
  assign last_beat    = active && (beat_idx == beats_q - BW'(1));
  // Refill on the last beat so consecutive vectors stream without a bubble.
  assign pop          = run && !fifo_empty && (!active || last_beat);
  assign layer_end    = run && last_beat && (node_cnt == num_nodes_q - NN_W'(1));

  feature_writeback_fifo #(.W(VW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start),
    .push     (push),
    .push_dat (new_feat),
    .pop      (pop),
    .pop_dat  (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    lane_dat = '0;
    for (int j = 0; j < LANES; j++) begin
      if (int'(beat_idx)*LANES + j < int'(num_feat_q))
        lane_dat[j*FEAT_W +: FEAT_W] = xform(lane_elem(cur_vec, int'(beat_idx)*LANES + j), shift_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      num_feat_q      <= '0;
      num_nodes_q     <= '0;
      shift_q         <= '0;
      beats_q         <= '0;
      beat_idx        <= '0;
      accept_cnt      <= '0;
      node_cnt        <= '0;
      addr_cnt        <= '0;
      active          <= 1'b0;
      cur_vec         <= '0;
      feat_bram_ena   <= 1'b0;
      feat_bram_addra <= '0;
      feat_bram_din   <= '0;
      gat_ready       <= 1'b0;
    end else if (start) begin
      state           <= RUN;
      num_feat_q      <= num_feat;
      num_nodes_q     <= num_nodes;
      shift_q         <= shift_amt;
      beats_q         <= beats_next;
      beat_idx        <= '0;
      accept_cnt      <= '0;
      node_cnt        <= '0;
      addr_cnt        <= '0;
      active          <= 1'b0;
      feat_bram_ena   <= 1'b0;
      feat_bram_addra <= '0;
      feat_bram_din   <= '0;
      gat_ready       <= 1'b0;
    end else begin
      feat_bram_ena <= run && active;
      if (run && active) begin
        feat_bram_addra <= addr_cnt;
        feat_bram_din   <= lane_dat;
        addr_cnt        <= addr_cnt + ADDR_W'(1);
        if (last_beat) begin
          node_cnt <= node_cnt + NN_W'(1);
          beat_idx <= '0;
        end else begin
          beat_idx <= beat_idx + BW'(1);
        end
      end
      if (pop) begin
        cur_vec  <= fifo_dout;
        active   <= 1'b1;
        beat_idx <= '0;
      end else if (last_beat) begin
        active <= 1'b0;
      end
      if (push) accept_cnt <= accept_cnt + NN_W'(1);
      if (layer_end) state <= DONE;
      if (state == DONE) gat_ready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_feature_writeback_ctrl.sv
// Scoreboard bench for feature_writeback_ctrl: stimulus pushes expected BRAM beats, a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_feature_writeback_ctrl;
  localparam int FEAT_W = 32;
  localparam int NFM    = 16;
  localparam int LANES  = 2;
  localparam int ADDR_W = 15;
  localparam int NF_W   = 5;
  localparam int NN_W   = 12;

  typedef struct packed {
    logic [ADDR_W-1:0]       addr;
    logic [LANES*FEAT_W-1:0] din;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic                    start;
  logic [NF_W-1:0]         num_feat;
  logic [NN_W-1:0]         num_nodes;
  logic [4:0]              shift_amt;
  logic [NFM*FEAT_W-1:0]   new_feat;
  logic                    new_feat_vld;
  logic                    new_feat_rdy;
  logic [ADDR_W-1:0]       feat_bram_addra;
  logic [LANES*FEAT_W-1:0] feat_bram_din;
  logic                    feat_bram_ena;
  logic                    busy;
  logic                    gat_ready;

  feature_writeback_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .num_feat        (num_feat),
    .num_nodes       (num_nodes),
    .shift_amt       (shift_amt),
    .new_feat        (new_feat),
    .new_feat_vld    (new_feat_vld),
    .new_feat_rdy    (new_feat_rdy),
    .feat_bram_addra (feat_bram_addra),
    .feat_bram_din   (feat_bram_din),
    .feat_bram_ena   (feat_bram_ena),
    .busy            (busy),
    .gat_ready       (gat_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t exp_q[$];
  int m_nf, m_sh, m_addr;
  int acc_count, last_acc_cyc;
  int beats_seen, first_ena_cyc, last_ena_cyc, gr_rise_cyc;
  logic [ADDR_W-1:0]       first_addr, last_addr;
  logic [LANES*FEAT_W-1:0] first_din;
  logic [LANES*FEAT_W-1:0] got_din [64];
  logic gr_prev = 1'b0;
  int drop_acc = -1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference transform: floor division by 2^sh on the signed value.
  function automatic logic [31:0] xf(input logic [31:0] e, input int sh);
    longint v, d, r;
    v = longint'($signed(e));
`ifdef FEAT_RELU_EN
    if (v < 0) v = 0;
`endif
    d = longint'(1) << sh;
    if (v >= 0) r = v / d;
    else        r = -((-v + d - 1) / d);
    return r[31:0];
  endfunction

  function automatic logic [NFM*FEAT_W-1:0] ramp(input int base);
    logic [NFM*FEAT_W-1:0] v;
    for (int i = 0; i < NFM; i++) v[i*FEAT_W +: FEAT_W] = 32'(base + i);
    return v;
  endfunction

  task automatic push_expected(input logic [NFM*FEAT_W-1:0] v);
    int nbeats;
    beat_t b;
    nbeats = (m_nf + LANES - 1) / LANES;
    for (int k = 0; k < nbeats; k++) begin
      b.addr = ADDR_W'(m_addr);
      b.din  = '0;
      for (int j = 0; j < LANES; j++) begin
        if (k*LANES + j < m_nf) b.din[j*FEAT_W +: FEAT_W] = xf(v[(k*LANES+j)*FEAT_W +: FEAT_W], m_sh);
      end
      exp_q.push_back(b);
      m_addr++;
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (gat_ready && !gr_prev) gr_rise_cyc = cyc;
    gr_prev = gat_ready;
    if (busy && new_feat_vld && !new_feat_rdy && drop_acc < 0) drop_acc = acc_count;
    if (rst_n && feat_bram_ena) begin
      if (beats_seen == 0) begin
        first_ena_cyc = cyc;
        first_din     = feat_bram_din;
        first_addr    = feat_bram_addra;
      end
      beats_seen++;
      last_ena_cyc = cyc;
      last_addr    = feat_bram_addra;
      if (feat_bram_addra < 64) got_din[feat_bram_addra[5:0]] = feat_bram_din;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat addr=%0d din=%h expected=none", feat_bram_addra, feat_bram_din);
      end else begin
        e = exp_q.pop_front();
        check("beat_addr", 64'(feat_bram_addra), 64'(e.addr));
        check("beat_din", feat_bram_din, e.din);
      end
    end
  end

  // Callers are positioned 1 time unit after a rising edge.
  task automatic do_start(input int nf, input int nn, input int sh);
    start = 1'b1; num_feat = NF_W'(nf); num_nodes = NN_W'(nn); shift_amt = 5'(sh);
    @(posedge clk); #1;
    start = 1'b0;
    num_feat = 5'd3; num_nodes = 12'd1; shift_amt = 5'd7;
    exp_q.delete();
    m_nf = nf; m_sh = sh; m_addr = 0;
    beats_seen = 0; acc_count = 0; drop_acc = -1;
  endtask

  task automatic send_vec(input logic [NFM*FEAT_W-1:0] v);
    bit ok;
    ok = 1'b0;
    new_feat = v; new_feat_vld = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (new_feat_rdy) begin
        push_expected(v);
        ok = 1'b1;
        acc_count++;
        last_acc_cyc = cyc + 1;
      end
      @(posedge clk); #1;
    end
    new_feat_vld = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout accepted=0 required=1");
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (gat_ready) ok = 1'b1;
    end
    check(name, 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [NFM*FEAT_W-1:0] v;
    int t_acc, rdy_hi;
    bit ok;
    rst_n = 1'b0; start = 1'b0; num_feat = '0; num_nodes = '0; shift_amt = '0;
    new_feat = '0; new_feat_vld = 1'b0;
    beats_seen = 0; acc_count = 0;
    #12;
    check("reset_outputs", {feat_bram_ena, busy, gat_ready, new_feat_rdy, 60'(feat_bram_addra)}, 64'd0);
    check("reset_din", feat_bram_din, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-width vectors, three nodes
    do_start(16, 3, 0);
    send_vec(ramp(0));
    t_acc = last_acc_cyc;
    send_vec(ramp(100));
    send_vec(ramp(200));
    wait_done("t1_done");
    check("t1_latency", 64'(first_ena_cyc - t_acc), 64'd2);
    check("t1_first_din", first_din, {32'd1, 32'd0});
    check("t1_first_addr", 64'(first_addr), 64'd0);
    check("t1_last_addr", 64'(last_addr), 64'd23);
    check("t1_beats", 64'(beats_seen), 64'd24);
    check("t1_gat_ready_delay", 64'(gr_rise_cyc - last_ena_cyc), 64'd1);
    check("t1_busy_done", 64'(busy), 64'd0);

    // Odd feature count: padding lane and node stride
    do_start(7, 2, 0);
    check("t2_gat_cleared", 64'(gat_ready), 64'd0);
    send_vec(ramp(10));
    send_vec(ramp(50));
    wait_done("t2_done");
    check("t2_pad_beat", got_din[3], {32'd0, 32'd16});
    check("t2_node1_addr4", got_din[4], {32'd51, 32'd50});
    check("t2_beats", 64'(beats_seen), 64'd8);

    // Arithmetic shift of negative / positive elements
    do_start(2, 1, 1);
    v = '0; v[31:0] = 32'hFFFF_FFFB; v[63:32] = 32'd9;
    send_vec(v);
    wait_done("t3_done");
`ifdef FEAT_RELU_EN
    check("t3_shift", got_din[0], {32'd4, 32'd0});
`else
    check("t3_shift", got_din[0], {32'd4, 32'hFFFF_FFFD});
`endif

    // Continuous offer: FIFO fills, ready backs off, stream stays dense
    do_start(16, 6, 0);
    for (int n = 0; n < 6; n++) send_vec(ramp(1000*n + 3));
    wait_done("t4_done");
    check("t4_accepts_before_drop", 64'(drop_acc), 64'd5);
    check("t4_beats", 64'(beats_seen), 64'd48);
    check("t4_continuous", 64'(last_ena_cyc - first_ena_cyc), 64'd47);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // Restart mid-layer
    do_start(16, 4, 0);
    send_vec(ramp(1000));
    send_vec(ramp(2000));
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (beats_seen >= 5) ok = 1'b1;
    end
    check("t5_reach_5_beats", 64'(ok), 64'd1);
    @(posedge clk); #1;
    do_start(2, 1, 0);
    check("t5_gat_after_restart", 64'(gat_ready), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    check("t5_flushed_beats", 64'(beats_seen), 64'd0);
    check("t5_gat_idle", 64'(gat_ready), 64'd0);
    v = '0; v[31:0] = 32'd3; v[63:32] = 32'd7;
    send_vec(v);
    wait_done("t5_done");
    check("t5_first_addr", 64'(first_addr), 64'd0);
    check("t5_first_din", first_din, {32'd7, 32'd3});

    // Reset in the middle of a beat
    do_start(16, 1, 0);
    send_vec(ramp(500));
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (feat_bram_ena) ok = 1'b1;
    end
    check("t6_saw_beat", 64'(ok), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_reset_ctrl", {feat_bram_ena, busy, gat_ready, new_feat_rdy, 60'(feat_bram_addra)}, 64'd0);
    check("t6_reset_din", feat_bram_din, 64'd0);
    exp_q.delete();
    beats_seen = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    new_feat = ramp(7); new_feat_vld = 1'b1;
    rdy_hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (new_feat_rdy) rdy_hi++;
    end
    new_feat_vld = 1'b0;
    check("t6_rdy_idle", 64'(rdy_hi), 64'd0);
    check("t6_no_writes", 64'(beats_seen), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog_timeout time=%0t limit=500000", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
